// File: rtl/kmeans_pkg.sv
// Shared types and helpers for the K-means cluster accumulator.
// Holds default sizes, the recompute state encoding and a priority one-hot decoder.
package kmeans_pkg;

    localparam int CORES_DEF   = 16;
    localparam int COORD_W_DEF = 8;
    localparam int CNT_W_DEF   = 12;
    localparam int MAX_CORES   = 64;

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_LOAD,
        ST_DIV,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int onehot_lowest_idx(input logic [MAX_CORES-1:0] vec);
        int r;
        r = 0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (vec[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/cluster_accumulator_if.sv
// Point input, update request and centroid stream of the cluster accumulator.
// The master side drives points and requests; the slave side is the accumulator.
interface cluster_accumulator_if
    import kmeans_pkg::*;
#(
    parameter int CORES   = CORES_DEF,
    parameter int COORD_W = COORD_W_DEF
);
    logic                     pt_valid;
    logic                     pt_ready;
    logic [COORD_W-1:0]       pt_x;
    logic [COORD_W-1:0]       pt_y;
    logic [CORES-1:0]         closest_core;
    logic                     update_req;
    logic                     busy;
    logic                     cent_valid;
    logic [$clog2(CORES)-1:0] cent_idx;
    logic [COORD_W-1:0]       cent_x;
    logic [COORD_W-1:0]       cent_y;
    logic                     cent_en;
    logic                     done;
    logic                     overflow;

    modport master (
        output pt_valid, pt_x, pt_y, closest_core, update_req,
        input  pt_ready, busy, cent_valid, cent_idx, cent_x, cent_y, cent_en, done, overflow
    );

    modport slave (
        input  pt_valid, pt_x, pt_y, closest_core, update_req,
        output pt_ready, busy, cent_valid, cent_idx, cent_x, cent_y, cent_en, done, overflow
    );

endinterface

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle. The first step is taken on the
// start edge, so the quotient is final DIVIDEND_W-1 cycles after start.
module serial_divider #(
    parameter int DIVIDEND_W = 20,
    parameter int DIVISOR_W  = 12,
    parameter int Q_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic [Q_W-1:0]        quotient
);
    localparam int STEP_W = $clog2(DIVIDEND_W);

    logic [DIVIDEND_W-1:0] work, src_work, next_work;
    logic [DIVISOR_W-1:0]  rem, src_rem, next_rem;
    logic [DIVISOR_W-1:0]  dvsr, src_dvsr;
    logic [DIVISOR_W:0]    trial;
    logic                  ge;
    logic [STEP_W-1:0]     steps;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        src_work  = start ? dividend : work;
        src_rem   = start ? '0 : rem;
        src_dvsr  = start ? divisor : dvsr;
        trial     = {src_rem, src_work[DIVIDEND_W-1]};
        ge        = trial >= {1'b0, src_dvsr};
        next_rem  = ge ? DIVISOR_W'(trial - {1'b0, src_dvsr}) : trial[DIVISOR_W-1:0];
        next_work = {src_work[DIVIDEND_W-2:0], ge};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            rem   <= '0;
            dvsr  <= '0;
            steps <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            work  <= next_work;
            rem   <= next_rem;
            dvsr  <= divisor;
            steps <= STEP_W'(DIVIDEND_W - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            work  <= next_work;
            rem   <= next_rem;
            steps <= steps - 1'b1;
            if (steps == STEP_W'(1)) busy <= 1'b0;
        end
    end

    assign quotient = work[Q_W-1:0];

endmodule

// File: rtl/cluster_accumulator.sv
// Accumulates per-cluster coordinate sums and counts, then on request streams
// each cluster's mean as a new centroid, one per cluster, followed by a done pulse.
module cluster_accumulator
    import kmeans_pkg::*;
#(
    parameter int CORES   = CORES_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    cluster_accumulator_if.slave  bus
);
    localparam int SUM_W = COORD_W + CNT_W;
    localparam int IDX_W = $clog2(CORES);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               busy_q;
    logic               cent_valid_q;
    logic [IDX_W-1:0]   cent_idx_q;
    logic [COORD_W-1:0] cent_x_q;
    logic [COORD_W-1:0] cent_y_q;
    logic               cent_en_q;
    logic               done_q;
    logic               overflow_q;

    logic [SUM_W-1:0]   sum_x [CORES];
    logic [SUM_W-1:0]   sum_y [CORES];
    logic [CNT_W-1:0]   cnt   [CORES];

    logic [MAX_CORES-1:0] core_vec;
    logic [IDX_W-1:0]     pt_idx;
    logic                 accept;
    logic                 div_start;
    logic                 div_busy_x, div_busy_y;
    logic [COORD_W-1:0]   quo_x, quo_y;

    assign core_vec  = {{(MAX_CORES - CORES){1'b0}}, bus.closest_core};
    assign pt_idx    = IDX_W'(onehot_lowest_idx(core_vec));
    assign accept    = bus.pt_valid & ~busy_q;
    assign div_start = (state == ST_LOAD) && (cnt[idx] != '0);

    serial_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_W), .Q_W(COORD_W)) u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (sum_x[idx]),
        .divisor  (cnt[idx]),
        .busy     (div_busy_x),
        .quotient (quo_x)
    );

    serial_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_W), .Q_W(COORD_W)) u_div_y (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (sum_y[idx]),
        .divisor  (cnt[idx]),
        .busy     (div_busy_y),
        .quotient (quo_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ACCUM;
            idx          <= '0;
            busy_q       <= 1'b0;
            cent_valid_q <= 1'b0;
            cent_idx_q   <= '0;
            cent_x_q     <= '0;
            cent_y_q     <= '0;
            cent_en_q    <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            // NOTE: the accumulator array is reset because an aborted recompute must leave every cluster empty.
            for (int i = 0; i < CORES; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            cent_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    if (accept && (bus.closest_core != '0)) begin
                        if (cnt[pt_idx] == {CNT_W{1'b1}}) begin
                            overflow_q <= 1'b1;
                        end else begin
                            sum_x[pt_idx] <= sum_x[pt_idx] + SUM_W'(bus.pt_x);
                            sum_y[pt_idx] <= sum_y[pt_idx] + SUM_W'(bus.pt_y);
                            cnt[pt_idx]   <= cnt[pt_idx] + 1'b1;
                        end
                    end
                    if (bus.update_req) begin
                        state  <= ST_LOAD;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cnt[idx] == '0) begin
                        state        <= ST_EMIT;
                        cent_valid_q <= 1'b1;
                        cent_idx_q   <= idx;
                        cent_x_q     <= '0;
                        cent_y_q     <= '0;
                        cent_en_q    <= 1'b0;
                    end else begin
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (!(div_busy_x || div_busy_y)) begin
                        state        <= ST_EMIT;
                        cent_valid_q <= 1'b1;
                        cent_idx_q   <= idx;
                        cent_x_q     <= quo_x;
                        cent_y_q     <= quo_y;
                        cent_en_q    <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    sum_x[idx] <= '0;
                    sum_y[idx] <= '0;
                    cnt[idx]   <= '0;
                    if (idx == IDX_W'(CORES - 1)) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state  <= ST_ACCUM;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_ACCUM;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pt_ready   = ~busy_q;
    assign bus.busy       = busy_q;
    assign bus.cent_valid = cent_valid_q;
    assign bus.cent_idx   = cent_idx_q;
    assign bus.cent_x     = cent_x_q;
    assign bus.cent_y     = cent_y_q;
    assign bus.cent_en    = cent_en_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_cluster_accumulator.sv
// Scoreboard bench for cluster_accumulator: a default instance plus a CNT_W=2
// instance for count saturation, each with its own expected-output queue.
module tb_cluster_accumulator;
    import kmeans_pkg::*;

    localparam int CORES   = 16;
    localparam int COORD_W = 8;

    typedef struct {
        bit is_done;
        int idx;
        int x;
        int y;
        int en;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   exp_x [CORES];
    int   exp_y [CORES];
    int   exp_en[CORES];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cluster_accumulator_if #(.CORES(CORES), .COORD_W(COORD_W)) bus0 ();
    cluster_accumulator_if #(.CORES(CORES), .COORD_W(COORD_W)) bus1 ();

    cluster_accumulator #(.CORES(CORES), .COORD_W(COORD_W), .CNT_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    cluster_accumulator #(.CORES(CORES), .COORD_W(COORD_W), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic score(input int sel, input logic d, input int idx, input int x,
                         input int y, input int en);
        exp_t e;
        int   depth;
        depth = (sel == 0) ? q0.size() : q1.size();
        check($sformatf("dut%0d_output_expected", sel), depth > 0, 1);
        if (depth == 0) return;
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_kind_done", sel), d, e.is_done);
        if (!e.is_done) begin
            check($sformatf("dut%0d_cent_idx", sel), idx, e.idx);
            check($sformatf("dut%0d_cent_x_idx%0d", sel, e.idx), x, e.x);
            check($sformatf("dut%0d_cent_y_idx%0d", sel, e.idx), y, e.y);
            check($sformatf("dut%0d_cent_en_idx%0d", sel, e.idx), en, e.en);
        end
        if (e.cyc >= 0) check($sformatf("dut%0d_strobe_cycle", sel), cyc + 1, e.cyc);
    endtask

    always @(negedge clk) begin
        if (bus0.cent_valid || bus0.done)
            score(0, bus0.done, int'(bus0.cent_idx), int'(bus0.cent_x), int'(bus0.cent_y), int'(bus0.cent_en));
        if (bus1.cent_valid || bus1.done)
            score(1, bus1.done, int'(bus1.cent_idx), int'(bus1.cent_x), int'(bus1.cent_y), int'(bus1.cent_en));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pt(input int sel, input logic v, input int x, input int y,
                            input logic [CORES-1:0] core);
        if (sel == 0) begin
            bus0.pt_valid = v; bus0.pt_x = COORD_W'(x); bus0.pt_y = COORD_W'(y); bus0.closest_core = core;
        end else begin
            bus1.pt_valid = v; bus1.pt_x = COORD_W'(x); bus1.pt_y = COORD_W'(y); bus1.closest_core = core;
        end
    endtask

    task automatic set_upd(input int sel, input logic v);
        if (sel == 0) bus0.update_req = v;
        else bus1.update_req = v;
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic send_point(input int sel, input int x, input int y, input logic [CORES-1:0] core);
        drive_pt(sel, 1'b1, x, y, core);
        tick();
        drive_pt(sel, 1'b0, 0, 0, '0);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < CORES; i++) begin
            exp_x[i] = 0; exp_y[i] = 0; exp_en[i] = 0;
        end
    endtask

    // Pushes one full round (16 centroids then done); k < 0 means timing is not checked.
    task automatic push_round(input int sel, input int k);
        exp_t e;
        for (int i = 0; i < CORES; i++) begin
            e.is_done = 1'b0; e.idx = i; e.x = exp_x[i]; e.y = exp_y[i]; e.en = exp_en[i];
            e.cyc = (k < 0) ? -1 : k + 2 + 2 * i;
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
        e.is_done = 1'b1; e.idx = 0; e.x = 0; e.y = 0; e.en = 0;
        e.cyc = (k < 0) ? -1 : k + 33;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        clear_exp();
    endtask

    task automatic request_update(input int sel, input bit timed, output int k);
        k = cyc + 1;
        push_round(sel, timed ? k : -1);
        set_upd(sel, 1'b1);
        tick();
        set_upd(sel, 1'b0);
    endtask

    task automatic wait_idle(input int sel, input string name);
        int n;
        n = 0;
        while (get_busy(sel) && n < 500) begin
            tick();
            n++;
        end
        check({name, "_finishes"}, get_busy(sel), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int   k;
        exp_t e;
        drive_pt(0, 1'b0, 0, 0, '0);
        drive_pt(1, 1'b0, 0, 0, '0);
        set_upd(0, 1'b0);
        set_upd(1, 1'b0);
        clear_exp();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset state
        check("rst_pt_ready", bus0.pt_ready, 1);
        check("rst_busy", bus0.busy, 0);
        check("rst_cent_valid", bus0.cent_valid, 0);
        check("rst_cent_idx", bus0.cent_idx, 0);
        check("rst_cent_x", bus0.cent_x, 0);
        check("rst_cent_y", bus0.cent_y, 0);
        check("rst_cent_en", bus0.cent_en, 0);
        check("rst_done", bus0.done, 0);
        check("rst_overflow", bus0.overflow, 0);
        check("rst_sat_overflow", bus1.overflow, 0);

        // Three points to cluster 2: mean (61/3, 120/3) = (20, 40)
        send_point(0, 10, 20, 16'h0004);
        send_point(0, 20, 40, 16'h0004);
        send_point(0, 31, 60, 16'h0004);
        exp_x[2] = 20; exp_y[2] = 40; exp_en[2] = 1;
        request_update(0, 1'b0, k);
        wait_idle(0, "t1");

        // All empty, exact strobe timing, twice to confirm the clear
        request_update(0, 1'b1, k);
        wait_idle(0, "t2a");
        check("t2a_ready_cycle", cyc + 1, k + 34);
        check("t2a_pt_ready", bus0.pt_ready, 1);
        request_update(0, 1'b1, k);
        wait_idle(0, "t2b");
        check("t2b_ready_cycle", cyc + 1, k + 34);

        // Point accepted in the same cycle as update_req; a held point waits for pt_ready
        exp_x[0] = 100; exp_y[0] = 50; exp_en[0] = 1;
        push_round(0, -1);
        drive_pt(0, 1'b1, 100, 50, 16'h0001);
        set_upd(0, 1'b1);
        tick();
        set_upd(0, 1'b0);
        drive_pt(0, 1'b1, 5, 7, 16'h0002);
        check("t3_ready_low_while_busy", bus0.pt_ready, 0);
        wait_idle(0, "t3a");
        check("t3_ready_back", bus0.pt_ready, 1);
        tick();
        drive_pt(0, 1'b0, 0, 0, '0);
        exp_x[1] = 5; exp_y[1] = 7; exp_en[1] = 1;
        request_update(0, 1'b0, k);
        wait_idle(0, "t3b");

        // Multi-hot takes the lowest bit; zero one-hot is discarded
        send_point(0, 8, 8, 16'h0005);
        send_point(0, 200, 200, 16'h0000);
        exp_x[0] = 8; exp_y[0] = 8; exp_en[0] = 1;
        request_update(0, 1'b0, k);
        wait_idle(0, "t4");

        // Count saturation on the CNT_W=2 instance
        send_point(1, 10, 20, 16'h0008);
        send_point(1, 20, 30, 16'h0008);
        send_point(1, 30, 40, 16'h0008);
        check("t5_overflow_before", bus1.overflow, 0);
        send_point(1, 100, 100, 16'h0008);
        check("t5_overflow_after", bus1.overflow, 1);
        exp_x[3] = 20; exp_y[3] = 30; exp_en[3] = 1;
        request_update(1, 1'b0, k);
        wait_idle(1, "t5");
        check("t5_overflow_sticky", bus1.overflow, 1);

        // Reset in the middle of cluster 5's division
        send_point(0, 50, 50, 16'h0020);
        k = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            e.is_done = 1'b0; e.idx = i; e.x = 0; e.y = 0; e.en = 0; e.cyc = k + 2 + 2 * i;
            q0.push_back(e);
        end
        set_upd(0, 1'b1);
        tick();
        set_upd(0, 1'b0);
        repeat (14) tick();
        check("t6_busy_before_rst", bus0.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_busy_in_rst", bus0.busy, 0);
        check("t6_cent_valid_in_rst", bus0.cent_valid, 0);
        check("t6_done_in_rst", bus0.done, 0);
        check("t6_pt_ready_in_rst", bus0.pt_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        check("t6_no_pending_outputs", q0.size(), 0);
        request_update(0, 1'b1, k);
        wait_idle(0, "t6");
        check("t6_ready_cycle", cyc + 1, k + 34);

        repeat (4) tick();
        check("final_q0_drained", q0.size(), 0);
        check("final_q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
